// File: rtl/xalu_host_pkg.sv
// Shared types and constants for the xalu host sequencer: FSM states, pin phase codes
// and the bit positions of done/flags on the tile's bidirectional bus.
package xalu_host_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND_OP,
    SEND_A,
    SEND_B,
    WAIT,
    RESP
  } state_t;

  localparam logic [1:0] PH_IDLE = 2'b00;
  localparam logic [1:0] PH_OP   = 2'b01;
  localparam logic [1:0] PH_A    = 2'b10;
  localparam logic [1:0] PH_B    = 2'b11;

  localparam int DONE_BIT = 0;
  localparam int FLAG_LSB = 1;
  localparam int FLAG_MSB = 4;

endpackage

// File: rtl/xalu_host_timeout.sv
// WAIT-phase cycle counter: cleared before WAIT, counts each WAIT cycle and flags
// the cycle that is the TIMEOUT_CYCLES-th one spent waiting.
module xalu_host_timeout #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic limit_hit
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // count holds the number of WAIT cycles already completed, so the limit cycle is LIMIT-1
  assign limit_hit = enable && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/xalu_host_sequencer.sv
// Host-side sequencer for the xalu tile: accepts one command, serialises op/A/B onto
// the tile pins, waits for done (or times out) and returns result/flags on a response port.
module xalu_host_sequencer
  import xalu_host_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_op,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_result,
  output logic [3:0] rsp_flags,
  output logic       rsp_timeout,
  output logic [7:0] alu_ui,
  output logic [7:0] alu_uio,
  output logic       alu_ena,
  input  logic [7:0] alu_uo,
  input  logic [7:0] alu_uio_out,
  input  logic [7:0] alu_uio_oe
);

  state_t state, state_next;
  logic [7:0] a_q, b_q;
  logic       done;
  logic       limit_hit;
  logic       unused_bits;

  assign done        = alu_uio_out[DONE_BIT] & alu_uio_oe[DONE_BIT];
  assign req_ready   = rst_n && (state == IDLE);
  assign rsp_valid   = (state == RESP);
  assign unused_bits = ^{alu_uio_out[7:5], alu_uio_oe[7:5]};

  xalu_host_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (state == SEND_B),
    .enable   (state == WAIT),
    .limit_hit(limit_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = SEND_OP;
      SEND_OP: state_next = SEND_A;
      SEND_A:  state_next = SEND_B;
      SEND_B:  state_next = WAIT;
      WAIT:    if (done || limit_hit) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Pins are loaded one cycle ahead so each phase appears on the cycle its state is entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      alu_ui  <= '0;
      alu_uio <= '0;
      alu_ena <= 1'b0;
    end else begin
      alu_ena <= 1'b1;
      case (state)
        IDLE: begin
          if (req_valid) begin
            a_q     <= req_a;
            b_q     <= req_b;
            alu_ui  <= {4'b0000, req_op};
            alu_uio <= {PH_OP, 6'b000000};
          end else begin
            alu_ui  <= '0;
            alu_uio <= {PH_IDLE, 6'b000000};
          end
        end
        SEND_OP: begin
          alu_ui  <= a_q;
          alu_uio <= {PH_A, 6'b000000};
        end
        SEND_A: begin
          alu_ui  <= b_q;
          alu_uio <= {PH_B, 6'b000000};
        end
        default: begin
          alu_ui  <= '0;
          alu_uio <= {PH_IDLE, 6'b000000};
        end
      endcase
    end
  end

  // A done in the limit cycle still counts as a completion, not a timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result  <= '0;
      rsp_flags   <= '0;
      rsp_timeout <= 1'b0;
    end else if (state == WAIT) begin
      if (done) begin
        rsp_result  <= alu_uo;
        rsp_flags   <= alu_uio_out[FLAG_MSB:FLAG_LSB] & alu_uio_oe[FLAG_MSB:FLAG_LSB];
        rsp_timeout <= 1'b0;
      end else if (limit_hit) begin
        rsp_result  <= '0;
        rsp_flags   <= '0;
        rsp_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_xalu_host_sequencer.sv
// Scoreboard bench for xalu_host_sequencer: a behavioural tile model answers with a
// configurable done delay; a negedge monitor compares every response handshake.
module tb_xalu_host_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_op;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic [3:0] rsp_flags;
  logic       rsp_timeout;
  logic [7:0] alu_ui;
  logic [7:0] alu_uio;
  logic       alu_ena;
  logic [7:0] alu_uo;
  logic [7:0] alu_uio_out;
  logic [7:0] alu_uio_oe;

  typedef struct packed {
    logic [7:0] result;
    logic [3:0] flags;
    logic       timeout;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_compared = 0;
  int   n_failed   = 0;

  // Tile model: done pulses on the model_delay-th WAIT cycle (0 = never)
  logic [7:0] model_uo    = 8'h00;
  logic [3:0] model_flags = 4'h0;
  logic [7:0] model_oe    = 8'hFF;
  logic       model_force = 1'b0;
  int         model_delay = 0;
  int         wait_cyc    = 0;
  logic       model_done;

  always #5 clk = ~clk;

  xalu_host_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .rsp_timeout(rsp_timeout),
    .alu_ui     (alu_ui),
    .alu_uio    (alu_uio),
    .alu_ena    (alu_ena),
    .alu_uo     (alu_uo),
    .alu_uio_out(alu_uio_out),
    .alu_uio_oe (alu_uio_oe)
  );

  always @(posedge clk) begin
    if (alu_uio[7:6] == 2'b11) wait_cyc <= 1;
    else if (wait_cyc != 0 && wait_cyc < 1000) wait_cyc <= wait_cyc + 1;
  end

  assign model_done  = model_force || (model_delay != 0 && wait_cyc == model_delay);
  assign alu_uo      = model_uo;
  assign alu_uio_out = {3'b000, model_flags, model_done};
  assign alu_uio_oe  = model_oe;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every accepted response is compared against the oldest expectation
  always @(negedge clk) begin
    rsp_t e;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_compared++;
        n_failed++;
        $display("[TB] FAIL unexpected_rsp: got result 0x%0h with no expectation queued", rsp_result);
      end else begin
        e = exp_q.pop_front();
        check_output("rsp_result", rsp_result, e.result);
        check_output("rsp_flags", rsp_flags, e.flags);
        check_output("rsp_timeout", rsp_timeout, e.timeout);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_model(input int delay, input logic [7:0] uo, input logic [3:0] flags, input logic [7:0] oe);
    model_delay = delay;
    model_uo    = uo;
    model_flags = flags;
    model_oe    = oe;
  endtask

  // Returns #1 into cycle 1 (the cycle after the handshake edge)
  task automatic apply_stimulus(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                input bit expect_rsp, input rsp_t e);
    int guard;
    if (expect_rsp) exp_q.push_back(e);
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    guard     = 0;
    while (!req_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!req_ready) begin
      check_output("req_handshake", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    tick();
    req_valid = 1'b0;
    req_op    = ~op;
    req_a     = ~a;
    req_b     = ~b;
  endtask

  task automatic run_timed(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                           input rsp_t e, input int rsp_cycle, input string name);
    apply_stimulus(op, a, b, 1'b1, e);
    for (int c = 1; c < rsp_cycle - 1; c++) tick();
    check_output({name, "_valid_early"}, rsp_valid, 1'b0);
    tick();
    check_output({name, "_valid"}, rsp_valid, 1'b1);
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int guard;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;

    repeat (2) tick();
    check_output("reset_req_ready", req_ready, 1'b0);
    check_output("reset_rsp_valid", rsp_valid, 1'b0);
    check_output("reset_alu_ui", alu_ui, 8'h00);
    check_output("reset_alu_uio", alu_uio, 8'h00);
    check_output("reset_alu_ena", alu_ena, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_output("post_reset_req_ready", req_ready, 1'b1);
    check_output("post_reset_alu_ena", alu_ena, 1'b1);

    $display("[TB] basic command with pin sequencing");
    set_model(2, 8'h41, 4'b0010, 8'hFF);
    apply_stimulus(4'h1, 8'h3C, 8'h05, 1'b1, '{8'h41, 4'h2, 1'b0});
    check_output("pin_op_uio", alu_uio, 8'h40);
    check_output("pin_op_ui", alu_ui, 8'h01);
    check_output("busy_req_ready", req_ready, 1'b0);
    tick();
    check_output("pin_a_uio", alu_uio, 8'h80);
    check_output("pin_a_ui", alu_ui, 8'h3C);
    tick();
    check_output("pin_b_uio", alu_uio, 8'hC0);
    check_output("pin_b_ui", alu_ui, 8'h05);
    tick();
    check_output("pin_wait_uio", alu_uio, 8'h00);
    check_output("pin_wait_ui", alu_ui, 8'h00);
    check_output("basic_valid_c4", rsp_valid, 1'b0);
    tick();
    check_output("basic_valid_c5", rsp_valid, 1'b0);
    tick();
    check_output("basic_valid_c6", rsp_valid, 1'b1);
    tick();
    check_output("basic_after_valid", rsp_valid, 1'b0);
    check_output("basic_after_ready", req_ready, 1'b1);

    $display("[TB] timeout and oe gating");
    set_model(0, 8'hEE, 4'hF, 8'hFF);
    run_timed(4'h2, 8'h10, 8'h20, '{8'h00, 4'h0, 1'b1}, 20, "timeout");
    set_model(2, 8'h33, 4'hF, 8'hFE);
    run_timed(4'h3, 8'h11, 8'h22, '{8'h00, 4'h0, 1'b1}, 20, "oe_done_gated");
    set_model(3, 8'h99, 4'hF, 8'h0B);
    run_timed(4'h4, 8'h12, 8'h34, '{8'h99, 4'h5, 1'b0}, 7, "oe_flag_mask");

    $display("[TB] timeout boundary");
    set_model(16, 8'h5A, 4'h1, 8'hFF);
    run_timed(4'h5, 8'hA0, 8'h0A, '{8'h5A, 4'h1, 1'b0}, 20, "done_at_limit");
    set_model(17, 8'h6B, 4'h3, 8'hFF);
    run_timed(4'h6, 8'hB0, 8'h0B, '{8'h00, 4'h0, 1'b1}, 20, "done_past_limit");

    $display("[TB] stray done in idle");
    set_model(0, 8'h77, 4'hF, 8'hFF);
    model_force = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("stray_rsp_valid", rsp_valid, 1'b0);
      check_output("stray_req_ready", req_ready, 1'b1);
    end
    model_force = 1'b0;
    tick();

    $display("[TB] response backpressure");
    rsp_ready = 1'b0;
    set_model(1, 8'h7E, 4'hA, 8'hFF);
    apply_stimulus(4'h7, 8'h01, 8'h02, 1'b1, '{8'h7E, 4'hA, 1'b0});
    guard = 0;
    while (!rsp_valid && guard < 40) begin
      tick();
      guard++;
    end
    check_output("bp_rsp_arrived", rsp_valid, 1'b1);
    req_valid = 1'b1;
    req_op    = 4'h9;
    req_a     = 8'h55;
    req_b     = 8'hAA;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_output("bp_rsp_valid", rsp_valid, 1'b1);
      check_output("bp_result", rsp_result, 8'h7E);
      check_output("bp_flags", rsp_flags, 4'hA);
      check_output("bp_req_ready", req_ready, 1'b0);
      check_output("bp_pins_idle", alu_uio, 8'h00);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    check_output("bp_released", rsp_valid, 1'b0);

    $display("[TB] reset during SEND_A");
    set_model(2, 8'h44, 4'h4, 8'hFF);
    apply_stimulus(4'h8, 8'hC7, 8'h7C, 1'b0, '{8'h00, 4'h0, 1'b0});
    tick();
    check_output("abort_pin_a", alu_uio, 8'h80);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("abort_alu_ui", alu_ui, 8'h00);
    check_output("abort_alu_uio", alu_uio, 8'h00);
    check_output("abort_alu_ena", alu_ena, 1'b0);
    check_output("abort_req_ready", req_ready, 1'b0);
    check_output("abort_rsp_valid", rsp_valid, 1'b0);
    check_output("abort_rsp_result", rsp_result, 8'h00);
    check_output("abort_rsp_flags", rsp_flags, 4'h0);
    check_output("abort_rsp_timeout", rsp_timeout, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_output("abort_release_ready", req_ready, 1'b1);
    check_output("abort_release_uio", alu_uio, 8'h00);

    set_model(1, 8'hC3, 4'h8, 8'hFF);
    run_timed(4'h1, 8'h60, 8'h63, '{8'hC3, 4'h8, 1'b0}, 5, "recovery");

    guard = 0;
    while (exp_q.size() != 0 && guard < 40) begin
      tick();
      guard++;
    end
    check_output("scoreboard_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
